uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets four requesters share one uart_transmitter.
//   A grant loads the winner's byte into tx_data, strobes tx_start and ack for
//   one cycle, then follows the transmitter's busy flag until the frame ends.
//   If the transmitter never reports busy, the grant is abandoned after
//   BUSY_TIMEOUT cycles and timeout_err pulses.
//
// Ports
//   CLK_i        system clock (rising edge)
//   RST_i        asynchronous active-high reset
//   req[3:0]     per-requester level request
//   req_data     requester n's byte on [8n+7:8n]
//   ack[3:0]     one-cycle grant pulse, one-hot
//   tx_start     start strobe to transmitter TxD_start
//   tx_data      registered byte to transmitter TxD_data
//   tx_busy      transmitter TxD_busy
//   last_grant   index of the most recently granted requester
//   arb_busy     high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse when a grant is abandoned
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        CLK_i,
  input  logic        RST_i,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  last_grant,
  output logic        arb_busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(BUSY_TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  ack_q, ack_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  scan_idx;

  // Round-robin pick: scan starts one past the last grant and wraps. The
  // 2-bit add wraps naturally, so i=4 revisits last_grant itself last.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = 2'd0;
    scan_idx = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_grant_q + 2'(i);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ack_d         = 4'b0000;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    last_grant_d  = last_grant_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && win_vld) begin
          state_d      = ISSUE;
          ack_d        = 4'b0001 << win_idx;
          tx_start_d   = 1'b1;
          tx_data_d    = req_data[{win_idx, 3'b000} +: 8];
          last_grant_d = win_idx;
        end
      end
      ISSUE: begin
        state_d   = WAIT_BUSY;
        tmo_cnt_d = 8'd0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          // Transmitter never picked the byte up: drop the grant but keep
          // last_grant so the next scan still moves past this requester.
          if (tmo_cnt_q + 8'd1 == TMO_LIMIT) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q       <= IDLE;
      ack_q         <= 4'b0000;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      last_grant_q  <= 2'd3;
      tmo_cnt_q     <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      last_grant_q  <= last_grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign last_grant  = last_grant_q;
  assign arb_busy    = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by randomized
// traffic, checked against a round-robin reference model that tracks only the
// last granted index and the transmitter handshake seen by the bench.
module tb_uart_tx_arbiter;

  logic        CLK_i = 1'b0;
  logic        RST_i;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  last_grant;
  logic        arb_busy;
  logic        timeout_err;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          ptr;          // model: last granted requester
  int          last_w;       // model: winner of the most recent grant_cycle
  logic [7:0]  cur_byte;     // model: byte in flight
  logic [31:0] txd_word;
  bit          tmo_r;

  uart_tx_arbiter #(.BUSY_TIMEOUT(15)) dut (
    .CLK_i       (CLK_i),
    .RST_i       (RST_i),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .last_grant  (last_grant),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK_i = ~CLK_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Winner by the round-robin rule: first set request at (p+1), (p+2), ...
  // modulo 4; nothing is granted while the transmitter is busy.
  function automatic int pick(input int p, input logic [3:0] r, input logic busy);
    if (busy) return -1;
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  // One edge taken from IDLE: either a grant or nothing, as the model says.
  task automatic grant_cycle();
    int          w;
    logic [31:0] d;
    w = pick(ptr, req, tx_busy);
    d = req_data;
    tick();
    last_w = w;
    chk("timeout_err_low", timeout_err, 0);
    if (w < 0) begin
      chk("ack_none", ack, 0);
      chk("tx_start_none", tx_start, 0);
      chk("idle_not_busy", arb_busy, 0);
      chk("last_grant_keep", last_grant, ptr);
    end else begin
      ptr      = w;
      cur_byte = d[w*8 +: 8];
      chk("ack_onehot", ack, 1 << w);
      chk("tx_start_issue", tx_start, 1);
      chk("tx_data_load", tx_data, cur_byte);
      chk("last_grant_set", last_grant, w);
      chk("busy_issue", arb_busy, 1);
    end
  endtask

  // Transmitter behaviour after ISSUE: busy rises after dly idle cycles and
  // stays for flen cycles, or never rises (tmo). poke pulses req[3] while the
  // frame is in WAIT_DONE.
  task automatic run_frame(input int dly, input int flen, input bit tmo, input bit poke);
    tick();
    chk("ack_one_cycle", ack, 0);
    chk("tx_start_one_cycle", tx_start, 0);
    chk("tx_data_hold_wb", tx_data, cur_byte);
    chk("busy_wait", arb_busy, 1);
    if (tmo) begin
      for (int c = 0; c < 14; c++) begin
        tick();
        chk("tmo_not_yet", timeout_err, 0);
        chk("tmo_still_busy", arb_busy, 1);
      end
      tick();
      chk("tmo_pulse", timeout_err, 1);
      chk("tmo_idle", arb_busy, 0);
      chk("tmo_last_grant", last_grant, ptr);
      chk("tmo_no_ack", ack, 0);
    end else begin
      for (int c = 0; c < dly; c++) begin
        tick();
        chk("wb_busy", arb_busy, 1);
        chk("wb_no_tmo", timeout_err, 0);
        chk("wb_no_ack", ack, 0);
      end
      tx_busy = 1'b1;
      for (int c = 0; c < flen; c++) begin
        if (poke && c == 1) req[3] = 1'b1;
        if (poke && c == 2) req[3] = 1'b0;
        tick();
        chk("wd_no_ack", ack, 0);
        chk("wd_busy", arb_busy, 1);
        chk("wd_tx_data_hold", tx_data, cur_byte);
      end
      tx_busy = 1'b0;
      tick();
      chk("done_idle", arb_busy, 0);
      chk("done_no_ack", ack, 0);
      chk("done_tx_data_hold", tx_data, cur_byte);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_last_grant"}, last_grant, 3);
    chk({tag, "_arb_busy"}, arb_busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_i    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_busy  = 1'b0;
    ptr      = 3;
    cur_byte = 8'h00;
    last_w   = -1;
    tick();
    tick();
    chk_reset_vals("reset");

    // Requests pending during reset must not be granted until release.
    req      = 4'b1111;
    req_data = 32'h44434241;
    tick();
    chk("ack_in_reset", ack, 0);
    chk("tx_start_in_reset", tx_start, 0);
    RST_i = 1'b0;

    // All four requesting: 0,1,2,3 and the line carries "ABCD".
    txd_word = 32'h0;
    for (int g = 0; g < 4; g++) begin
      grant_cycle();
      chk("abcd_order", last_grant, g);
      txd_word = {txd_word[23:0], tx_data};
      run_frame(0, 5, 0, 0);
    end
    chk("txd_abcd", txd_word, 32'h41424344);

    // Two requesters held: alternate 0,2,0,2.
    req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      grant_cycle();
      chk("alt_grant", last_grant, (g % 2) * 2);
      run_frame(1, 3, 0, 0);
    end

    // Single persistent requester re-granted each frame; busy arrives one
    // cycle short of the timeout.
    req = 4'b0100;
    for (int g = 0; g < 2; g++) begin
      grant_cycle();
      chk("persist_grant", last_grant, 2);
      run_frame(14, 2, 0, 0);
    end

    // Transmitter never goes busy: timeout, then requester 1 granted again.
    req      = 4'b0010;
    req_data = 32'h00005A00;
    grant_cycle();
    chk("tmo_grant_ack", ack, 4'b0010);
    run_frame(0, 0, 1, 0);
    grant_cycle();
    chk("regrant_after_tmo", last_grant, 1);
    run_frame(0, 3, 0, 0);

    // Transmitter busy when the request arrives: held off until it falls.
    req = 4'b0000;
    grant_cycle();
    tx_busy = 1'b1;
    req     = 4'b1000;
    for (int c = 0; c < 3; c++) grant_cycle();
    tx_busy = 1'b0;
    grant_cycle();
    chk("grant_after_busy", last_grant, 3);
    run_frame(2, 3, 0, 0);

    // Requester 3 raises and withdraws while requester 0 is in WAIT_DONE.
    req = 4'b0001;
    grant_cycle();
    chk("withdraw_grant0", last_grant, 0);
    req = 4'b0000;
    run_frame(0, 5, 0, 1);
    grant_cycle();
    chk("withdraw_no_ack3", ack, 0);

    // Reset asserted mid-cycle in WAIT_DONE.
    req      = 4'b1111;
    req_data = 32'hDDCCBBAA;
    grant_cycle();
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    #2;
    RST_i = 1'b1;
    #1;
    chk_reset_vals("midframe_reset");
    ptr     = 3;
    tx_busy = 1'b0;
    tick();
    chk("ack_held_reset", ack, 0);
    RST_i = 1'b0;
    grant_cycle();
    chk("first_after_reset", last_grant, 0);
    run_frame(0, 4, 0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      req      = 4'($urandom_range(0, 15));
      req_data = $urandom();
      tx_busy  = ($urandom_range(0, 3) == 0);
      grant_cycle();
      tx_busy = 1'b0;
      if (last_w >= 0) begin
        // Post-ack changes must not disturb the byte in flight.
        req      = 4'($urandom_range(0, 15));
        req_data = $urandom();
        tmo_r    = ($urandom_range(0, 7) == 0);
        run_frame(int'($urandom_range(0, 14)), int'($urandom_range(1, 8)), tmo_r, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
